divider_4bit_seq: RTL and testbench
===================================

# divider_4bit_seq

Sequential 4-bit unsigned restoring divider. It computes quotient and remainder of a 4-bit dividend by a 4-bit divisor, one quotient bit per clock, MSB first. It sits directly upstream of `subtractor_4bit`: each cycle it drives the trial minuend and the divisor into one `subtractor_4bit` instance. It uses the returned `diff`/`borrow` to choose between the restore and subtract outcomes. It is the first sequential arithmetic stage built on the existing combinational subtractor.

## Interface
Parameters: none (widths fixed at 4 bits, matching `subtractor_4bit`).
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high; one clock domain
- start  in  1  request; sampled on rising edge when `busy`=0
- dividend  in  4  unsigned dividend; captured on accepted `start`
- divisor  in  4  unsigned divisor; captured on accepted `start`
- busy  out  1  high while an operation is in progress (RUN state)
- done  out  1  one-cycle pulse: `quotient`/`remainder`/`div_by_zero` valid
- quotient  out  4  result quotient; held until next accepted `start`
- remainder  out  4  result remainder; held until next accepted `start`
- div_by_zero  out  1  set with `done` when captured divisor = 0; held like the results

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE or DONE, `start`=1, divisor≠0:
  - capture operands into internal registers
  - R (partial remainder, 4 bits) ← 0; Q ← dividend; bit counter ← 3
  - go to RUN
- IDLE or DONE, `start`=1, divisor=0:
  - go to DONE without iterating
  - quotient ← 4'hF, remainder ← dividend, div_by_zero ← 1
- RUN, once per cycle:
  - trial = {R[2:0], Q[3]}
  - `subtractor_4bit` computes a=trial, b=divisor
  - if borrow=0: R ← diff, shift Q left with LSB ← 1
  - if borrow=1: R ← trial, shift Q left with LSB ← 0
  - counter decrements; when counter = 0 on this edge, load outputs from Q/R, div_by_zero ← 0, go to DONE
- Width rule: the partial remainder never exceeds the processed dividend prefix, so trial ≤ 15 always. A 4-bit trial is exact; no 5th bit is carried.
- DONE: `done`=1 for exactly this cycle. With no `start` this cycle, go to IDLE.
- `start` while RUN: ignored, no effect on the operation or the operands.
- Operand inputs are only sampled on an accepted `start`. Changes at other times are ignored.

## Timing
- Reset values (async, immediate): state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal R/Q/counter=0.
- Normal op: `start` accepted at edge E0; iterations at E1..E4. After E4: done=1 and results valid, i.e. latency 4 cycles from the accepting edge.
- busy=1 after E0 through E4; busy=0 in DONE.
- Divide-by-zero: done=1 after E0 (latency 1); busy stays 0.
- Back-to-back: `start` during the DONE cycle is accepted. Throughput is one result per 5 cycles; previous outputs hold until the new `done`.
- `rst` asserted mid-RUN: everything returns to reset values asynchronously. No `done` is produced for the aborted operation.
- `done` is never high in two consecutive cycles except for back-to-back divide-by-zero requests.

## Test plan
- Reset, then 13 ÷ 4 → done 4 cycles after start; quotient=3, remainder=1, div_by_zero=0; busy high exactly 4 cycles.
- Corner values:
  - 15 ÷ 1 → q=15, r=0
  - 15 ÷ 15 → q=1, r=0
  - 2 ÷ 7 → q=0, r=2
  - 0 ÷ 5 → q=0, r=0
- 9 ÷ 0 → done 1 cycle after start; q=4'hF, r=9, div_by_zero=1, busy never high. A following 6 ÷ 3 → q=2, r=0, div_by_zero=0.
- Start 14 ÷ 3; pulse `start` with 1 ÷ 1 during RUN → ignored; result q=4, r=2. Issue 7 ÷ 2 in the DONE cycle → accepted; q=3, r=1 four cycles later.
- Start 11 ÷ 2; assert `rst` asynchronously two cycles in → outputs zero immediately, no `done`. A later 11 ÷ 2 → q=5, r=1.
- Exhaustive sweep of all 256 operand pairs, issued back-to-back → every result matches the reference model (a/b, a%b; divisor 0 → q=15, r=a, div_by_zero=1).

Source files
------------

// File: rtl/divider_4bit_seq_if.sv
// Handshake and result bundle between a requester and the sequential 4-bit divider.
`timescale 1ns/1ps

interface divider_4bit_seq_if;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_4bit_seq.sv
// Sequential 4-bit unsigned restoring divider, one quotient bit per clock (MSB first),
// built around the combinational subtractor_4bit.
`timescale 1ns/1ps

module subtractor_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] diff,
    output logic       borrow
);
    assign {borrow, diff} = {1'b0, a} - {1'b0, b};
endmodule

module divider_4bit_seq (
    input  logic               clk,
    input  logic               rst,
    divider_4bit_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_r;
    logic [3:0] divisor_r;
    logic [3:0] rem_r;
    logic [3:0] quo_r;
    logic [1:0] cnt_r;
    logic       busy_r;
    logic       done_r;
    logic [3:0] quotient_r;
    logic [3:0] remainder_r;
    logic       div_by_zero_r;

    logic [3:0] trial_s;
    logic [3:0] diff_s;
    logic       borrow_s;

    // Trial minuend: partial remainder shifted left with the next dividend bit.
    // It never exceeds the processed dividend prefix, so 4 bits are exact.
    always_comb begin
        trial_s = {rem_r[2:0], quo_r[3]};
    end

    subtractor_4bit u_sub (
        .a      (trial_s),
        .b      (divisor_r),
        .diff   (diff_s),
        .borrow (borrow_s)
    );

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            divisor_r     <= 4'd0;
            rem_r         <= 4'd0;
            quo_r         <= 4'd0;
            cnt_r         <= 2'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            quotient_r    <= 4'd0;
            remainder_r   <= 4'd0;
            div_by_zero_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (bus.divisor != 4'd0) begin
                            divisor_r <= bus.divisor;
                            rem_r     <= 4'd0;
                            quo_r     <= bus.dividend;
                            cnt_r     <= 2'd3;
                            busy_r    <= 1'b1;
                            done_r    <= 1'b0;
                            state_r   <= RUN;
                        end else begin
                            // Zero divisor completes immediately with saturated quotient.
                            divisor_r     <= 4'd0;
                            quotient_r    <= 4'hF;
                            remainder_r   <= bus.dividend;
                            div_by_zero_r <= 1'b1;
                            busy_r        <= 1'b0;
                            done_r        <= 1'b1;
                            state_r       <= DONE;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    rem_r <= borrow_s ? trial_s : diff_s;
                    quo_r <= {quo_r[2:0], ~borrow_s};
                    cnt_r <= cnt_r - 2'd1;
                    if (cnt_r == 2'd0) begin
                        quotient_r    <= {quo_r[2:0], ~borrow_s};
                        remainder_r   <= borrow_s ? trial_s : diff_s;
                        div_by_zero_r <= 1'b0;
                        busy_r        <= 1'b0;
                        done_r        <= 1'b1;
                        state_r       <= DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = div_by_zero_r;
endmodule

// File: tb/tb_divider_4bit_seq.sv
// Self-checking bench for divider_4bit_seq: directed scenarios plus a shuffled
// back-to-back sweep of all operand pairs against an arithmetic reference model.
`timescale 1ns/1ps

module tb_divider_4bit_seq;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    divider_4bit_seq_if bus ();

    divider_4bit_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void ref_div(input logic [3:0] a, input logic [3:0] b,
                                    output logic [3:0] q, output logic [3:0] r,
                                    output logic dz);
        if (b == 4'd0) begin
            q = 4'd15; r = a; dz = 1'b1;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
    endfunction

    // Present a request for one clock; operands are scrambled afterwards.
    task automatic issue(input logic [3:0] a, input logic [3:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = 4'($urandom);
        bus.divisor  = 4'($urandom);
    endtask

    // Count edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int edges, output int busy_cnt);
        edges = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && edges < 12) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            edges++;
        end
        if (bus.busy === 1'b1) busy_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.dividend = 4'd0; bus.divisor = 4'd0;
        #3;
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero});
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int e, bc;
        issue(4'd13, 4'd4);
        wait_done(e, bc);
        checks++; if (e !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", e); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 4", bc); end
        checks++; if (bus.quotient !== 4'd3) begin errors++; $display("FAIL basic_q: got %0d expected 3", bus.quotient); end
        checks++; if (bus.remainder !== 4'd1) begin errors++; $display("FAIL basic_r: got %0d expected 1", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dz: got %0d expected 0", bus.div_by_zero); end
        @(posedge clk); #1;
        checks++; if ({bus.done, bus.busy} !== 2'b00) begin errors++; $display("FAIL basic_done_pulse: got done/busy=%b expected 00", {bus.done, bus.busy}); end
    endtask

    task automatic test_corners();
        logic [3:0] ta [4];
        logic [3:0] tb [4];
        logic [3:0] q, r;
        logic dz;
        int e, bc;
        ta[0] = 4'd15; tb[0] = 4'd1;
        ta[1] = 4'd15; tb[1] = 4'd15;
        ta[2] = 4'd2;  tb[2] = 4'd7;
        ta[3] = 4'd0;  tb[3] = 4'd5;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i]);
            wait_done(e, bc);
            ref_div(ta[i], tb[i], q, r, dz);
            checks++; if (e !== 4) begin errors++; $display("FAIL corner_latency %0d/%0d: got %0d expected 4", ta[i], tb[i], e); end
            checks++; if (bus.quotient !== q) begin errors++; $display("FAIL corner_q %0d/%0d: got %0d expected %0d", ta[i], tb[i], bus.quotient, q); end
            checks++; if (bus.remainder !== r) begin errors++; $display("FAIL corner_r %0d/%0d: got %0d expected %0d", ta[i], tb[i], bus.remainder, r); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        int e, bc;
        issue(4'd9, 4'd0);
        wait_done(e, bc);
        checks++; if (e !== 0) begin errors++; $display("FAIL dz_latency: got %0d expected 0", e); end
        checks++; if (bc !== 0) begin errors++; $display("FAIL dz_busy: got %0d expected 0", bc); end
        checks++; if (bus.quotient !== 4'hF) begin errors++; $display("FAIL dz_q: got %0d expected 15", bus.quotient); end
        checks++; if (bus.remainder !== 4'd9) begin errors++; $display("FAIL dz_r: got %0d expected 9", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %0d expected 1", bus.div_by_zero); end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL dz_done_pulse: got %0d expected 0", bus.done); end
        issue(4'd6, 4'd3);
        wait_done(e, bc);
        checks++; if (e !== 4) begin errors++; $display("FAIL dz_follow_latency: got %0d expected 4", e); end
        checks++; if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {4'd2, 4'd0, 1'b0})
            begin errors++; $display("FAIL dz_follow_result: got q=%0d r=%0d dz=%0d expected q=2 r=0 dz=0", bus.quotient, bus.remainder, bus.div_by_zero); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int e, bc;
        issue(4'd14, 4'd3);
        bus.start = 1'b1; bus.dividend = 4'd1; bus.divisor = 4'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(e, bc);
        checks++; if (e !== 3) begin errors++; $display("FAIL ignore_latency: got %0d expected 3", e); end
        checks++; if ({bus.quotient, bus.remainder} !== {4'd4, 4'd2})
            begin errors++; $display("FAIL ignore_result: got q=%0d r=%0d expected q=4 r=2", bus.quotient, bus.remainder); end
        issue(4'd7, 4'd2);
        checks++; if ({bus.done, bus.busy} !== 2'b01) begin errors++; $display("FAIL b2b_accept: got done/busy=%b expected 01", {bus.done, bus.busy}); end
        checks++; if (bus.quotient !== 4'd4) begin errors++; $display("FAIL b2b_hold_q: got %0d expected 4", bus.quotient); end
        wait_done(e, bc);
        checks++; if (e !== 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", e); end
        checks++; if ({bus.quotient, bus.remainder} !== {4'd3, 4'd1})
            begin errors++; $display("FAIL b2b_result: got q=%0d r=%0d expected q=3 r=1", bus.quotient, bus.remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int e, bc;
        int seen_done;
        issue(4'd11, 4'd2);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %b expected all zero",
                     {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero});
        end
        seen_done = 0;
        @(negedge clk); @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL async_no_done: got %0d active cycles expected 0", seen_done); end
        issue(4'd11, 4'd2);
        wait_done(e, bc);
        checks++; if (e !== 4) begin errors++; $display("FAIL async_rerun_latency: got %0d expected 4", e); end
        checks++; if ({bus.quotient, bus.remainder} !== {4'd5, 4'd1})
            begin errors++; $display("FAIL async_rerun_result: got q=%0d r=%0d expected q=5 r=1", bus.quotient, bus.remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep();
        int order [256];
        int j, tmp, e, bc, exp_e;
        logic [3:0] a, b, q, r;
        logic dz;
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int k = 0; k < 256; k++) begin
            a = 4'(order[k] >> 4);
            b = 4'(order[k]);
            issue(a, b);
            wait_done(e, bc);
            ref_div(a, b, q, r, dz);
            exp_e = (b == 4'd0) ? 0 : 4;
            checks++; if (e !== exp_e) begin errors++; $display("FAIL sweep_latency %0d/%0d: got %0d expected %0d", a, b, e, exp_e); end
            checks++; if (bus.quotient !== q) begin errors++; $display("FAIL sweep_q %0d/%0d: got %0d expected %0d", a, b, bus.quotient, q); end
            checks++; if (bus.remainder !== r) begin errors++; $display("FAIL sweep_r %0d/%0d: got %0d expected %0d", a, b, bus.remainder, r); end
            checks++; if (bus.div_by_zero !== dz) begin errors++; $display("FAIL sweep_dz %0d/%0d: got %0d expected %0d", a, b, bus.div_by_zero, dz); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_div_zero();
        test_back_to_back();
        test_async_reset();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
